auto_player: RTL and testbench

Self-test stimulus engine for the reflex game. It reads the game's `main_lights` vector and drives the `main_buttons` input to clear every lit bit, one button at a time. Each press is shaped to pass the game's rising-edge toggle detection. It sits beside the game core, on the opposite side of the buttons/lights interface, and is used for bring-up, bench regression and on-chip demo mode. It reports completion, failure and the number of presses issued.

---
 rtl/auto_player_pkg.sv | 32 +++
 rtl/auto_player_phase_timer.sv | 27 ++
 rtl/auto_player.sv | 174 +++++++++++++++++
 tb/tb_auto_player.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/auto_player_pkg.sv
// Shared types and constants for the auto_player stimulus engine.
package auto_player_pkg;

  localparam int unsigned NUM_BUTTONS = 8;
  // One extra bit so idx can reach NUM_BUTTONS for the final all-clear check.
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned COUNT_W     = 6;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StPress,
    StRelease,
    StSettle,
    StVerify,
    StDone,
    StFail
  } ap_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Press counter increments but never wraps.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/auto_player_phase_timer.sv
// Loadable down-counter that times the PRESS, RELEASE and SETTLE phases.
module phase_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement; the counter parks at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/auto_player.sv
// Drives the game's buttons to clear every lit bit, one shaped press at a time.
module auto_player
  import auto_player_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES    = 3,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic                   abort,
  input  logic [NUM_BUTTONS-1:0] lights,
  output logic [NUM_BUTTONS-1:0] presses,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [COUNT_W-1:0]     press_count
);

  localparam int unsigned TIMER_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, SETTLE_CYCLES) + 1);
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  ap_state_t          state;
  logic [IDX_W-1:0]   idx;
  logic [RETRY_W-1:0] retry;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_expired;

  logic                   lit;
  logic                   idx_end;
  logic                   retry_max;
  logic [NUM_BUTTONS-1:0] press_mask;

  assign idx_end    = idx[IDX_W-1];
  assign lit        = lights[idx[IDX_W-2:0]];
  assign retry_max  = (retry == RETRY_W'(MAX_RETRIES));
  assign press_mask = NUM_BUTTONS'(1) << idx[IDX_W-2:0];

  phase_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  // Load the phase timer with (length - 1) on the edge that enters a timed phase.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      StScan: begin
        if (!idx_end && lit) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(HOLD_CYCLES - 1);
        end
      end
      StVerify: begin
        if (lit && !retry_max) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(HOLD_CYCLES - 1);
        end
      end
      StPress: begin
        if (timer_expired) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(GAP_CYCLES - 1);
        end
      end
      StRelease: begin
        if (timer_expired) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(SETTLE_CYCLES - 1);
        end
      end
      default: ;
    endcase
  end

  // Solve sequencer with registered outputs; reset beats abort, abort beats go.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= StIdle;
      presses     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      press_count <= '0;
      idx         <= '0;
      retry       <= '0;
    end else if (abort && state != StIdle) begin
      state   <= StIdle;
      presses <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      unique case (state)
        StIdle: begin
          if (go) begin
            idx         <= '0;
            retry       <= '0;
            press_count <= '0;
            busy        <= 1'b1;
            state       <= StScan;
          end
        end
        StScan: begin
          if (idx_end) begin
            // Re-check all lights: catches a game restart mid-solve.
            if (lights == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state <= StFail;
              fail  <= 1'b1;
            end
          end else if (lit) begin
            state       <= StPress;
            presses     <= press_mask;
            press_count <= sat_inc(press_count);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        StPress: begin
          if (timer_expired) begin
            state   <= StRelease;
            presses <= '0;
          end
        end
        StRelease: begin
          if (timer_expired) state <= StSettle;
        end
        StSettle: begin
          if (timer_expired) state <= StVerify;
        end
        StVerify: begin
          if (!lit) begin
            retry <= '0;
            idx   <= idx + 1'b1;
            state <= StScan;
          end else if (retry_max) begin
            state <= StFail;
            fail  <= 1'b1;
          end else begin
            retry       <= retry + 1'b1;
            press_count <= sat_inc(press_count);
            presses     <= press_mask;
            state       <= StPress;
          end
        end
        StDone, StFail: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state   <= StIdle;
          presses <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player with a game model that toggles a light on each
// rising press edge and shows the new lights two cycles later.
module tb_auto_player;

  localparam int MAX_CYC = 150;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       go    = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] lights;
  logic [7:0] presses;
  logic       busy, done, fail;
  logic [5:0] press_count;

  // Game model state
  logic       model_load = 1'b0;
  logic [7:0] model_init = 8'h00;
  logic [7:0] ignore     = 8'h00;
  logic [7:0] inject     = 8'h00;
  logic [7:0] game, d1, d2, prev_press;

  int passed = 0;
  int total  = 0;

  // Per-solve results
  int         r_done_cyc, r_fail_cyc, r_pulses, r_rises, r_onehot_bad, r_count;
  logic       r_post_busy;
  logic [7:0] r_post_presses;
  logic [7:0] trace [0:MAX_CYC];

  typedef struct {
    logic [7:0] init;
    logic [7:0] ign;
    int         go_at;
    int         inject_at;
    int         exp_done;
    int         exp_fail;
    int         exp_count;
    int         exp_rises;
  } vec_t;

  vec_t vecs [7];

  auto_player dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .abort       (abort),
    .lights      (lights),
    .presses     (presses),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .press_count (press_count)
  );

  always #5 clock = ~clock;

  // Game core model: rising press edge toggles the bit, visible two cycles on.
  always @(posedge clock) begin
    if (model_load) begin
      game       <= model_init;
      d1         <= model_init;
      d2         <= model_init;
      prev_press <= 8'h00;
    end else begin
      prev_press <= presses;
      game       <= game ^ (presses & ~prev_press & ~ignore);
      d1         <= game;
      d2         <= d1;
    end
  end

  assign lights = d2 | inject;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    abort = 1'b0;
    go    = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_model(input logic [7:0] init, input logic [7:0] ign);
    @(negedge clock);
    model_init = init;
    ignore     = ign;
    inject     = 8'h00;
    model_load = 1'b1;
    @(negedge clock);
    model_load = 1'b0;
  endtask

  // Pulse go across edge 0; returns at the negedge inside cycle 1.
  task automatic pulse_go();
    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic run_solve(input logic [7:0] init, input logic [7:0] ign,
                           input int go_at, input int inject_at);
    logic [7:0] prev;
    int         end_cyc;
    do_reset();
    load_model(init, ign);
    pulse_go();
    r_done_cyc = 0; r_fail_cyc = 0; r_pulses = 0; r_rises = 0; r_onehot_bad = 0;
    r_count = -1; r_post_busy = 1'b1; r_post_presses = 8'hxx;
    prev = 8'h00;
    end_cyc = 0;
    for (int n = 1; n <= MAX_CYC; n++) begin
      if (n > 1) @(negedge clock);
      go = 1'b0;
      trace[n] = presses;
      if ($countones(presses) > 1) r_onehot_bad++;
      if ((presses & ~prev) != 8'h00) r_rises++;
      prev = presses;
      if (done || fail) r_pulses++;
      if (done && r_done_cyc == 0) r_done_cyc = n;
      if (fail && r_fail_cyc == 0) r_fail_cyc = n;
      if (n == go_at) go = 1'b1;
      if (n == inject_at) inject = 8'h80;
      if (end_cyc == 0 && (done || fail)) begin
        end_cyc = n;
      end else if (end_cyc != 0 && n == end_cyc + 1) begin
        r_post_busy    = busy;
        r_post_presses = presses;
        r_count        = press_count;
        break;
      end
    end
    go = 1'b0;
  endtask

  initial begin
    int   bad;
    int   rises;
    logic reached;
    logic [7:0] prev;
    logic [7:0] exp_p;

    //           init   ign   go_at inj  done fail cnt rises
    vecs[0] = '{8'h05, 8'h00, 0,    0,   30,  0,   2,  2};
    vecs[1] = '{8'h00, 8'h00, 0,    0,   10,  0,   0,  0};
    vecs[2] = '{8'h80, 8'h00, 0,    0,   20,  0,   1,  1};
    vecs[3] = '{8'hFF, 8'h00, 0,    0,   90,  0,   8,  8};
    vecs[4] = '{8'h08, 8'h08, 0,    0,   0,   45,  4,  4};
    vecs[5] = '{8'h01, 8'h00, 0,    19,  0,   20,  1,  1};
    vecs[6] = '{8'h05, 8'h00, 8,    0,   30,  0,   2,  2};

    // Reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_presses", presses, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_fail", fail, 0);
    check("reset_count", press_count, 0);

    // Table-driven solves
    for (int i = 0; i < 7; i++) begin
      run_solve(vecs[i].init, vecs[i].ign, vecs[i].go_at, vecs[i].inject_at);
      check($sformatf("v%0d_done_cycle", i), r_done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d_fail_cycle", i), r_fail_cyc, vecs[i].exp_fail);
      check($sformatf("v%0d_pulse_count", i), r_pulses, 1);
      check($sformatf("v%0d_press_count", i), r_count, vecs[i].exp_count);
      check($sformatf("v%0d_rising_edges", i), r_rises, vecs[i].exp_rises);
      check($sformatf("v%0d_post_busy", i), r_post_busy, 0);
      check($sformatf("v%0d_post_presses", i), r_post_presses, 0);
      check($sformatf("v%0d_onehot_violations", i), r_onehot_bad, 0);
    end

    // Cycle-exact press windows for lights=0x05
    run_solve(8'h05, 8'h00, 0, 0);
    bad = 0;
    for (int n = 1; n <= 31; n++) begin
      exp_p = (n >= 2 && n <= 5) ? 8'h01 : (n >= 14 && n <= 17) ? 8'h04 : 8'h00;
      if (trace[n] !== exp_p) begin
        bad++;
        $display("FAIL press_window cycle %0d: got 0x%0h, expected 0x%0h", n, trace[n], exp_p);
      end
    end
    check("press_window_errors", bad, 0);

    // Abort during the third PRESS of a 0xFF solve
    do_reset();
    load_model(8'hFF, 8'h00);
    pulse_go();
    rises = 0;
    prev = 8'h00;
    reached = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (n > 1) @(negedge clock);
      if ((presses & ~prev) != 8'h00) rises++;
      prev = presses;
      if (rises == 3) begin
        reached = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_presses", presses, 0);
        check("abort_busy", busy, 0);
        check("abort_pulse", {done, fail}, 0);
        check("abort_count", press_count, 3);
        bad = 0;
        repeat (15) begin
          @(negedge clock);
          if (done || fail || busy) bad++;
        end
        check("abort_quiet_after", bad, 0);
        break;
      end
    end
    check("abort_reached_third_press", reached, 1);

    // Reset in the middle of a PRESS
    do_reset();
    load_model(8'h05, 8'h00);
    pulse_go();
    reached = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(negedge clock);
      if (presses != 8'h00) begin
        reached = 1'b1;
        break;
      end
    end
    check("midpress_reached", reached, 1);
    reset = 1'b1;
    @(negedge clock);
    check("midpress_reset_presses", presses, 0);
    check("midpress_reset_busy", busy, 0);
    check("midpress_reset_count", press_count, 0);
    check("midpress_reset_pulse", {done, fail}, 0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
